// File: rtl/issue_regfile_pkg.sv
// Shared types and constants for the issue register file slice.
package issue_regfile_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREG   = 64;
  localparam int DEF_NBANK  = 2;
  localparam int DEF_ADDR_W = $clog2(DEF_NBANK * DEF_NREG);

  // Register address is {bank, index}; bank 0 holds integer, bank 1 float registers.
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FP  = 1'b1;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue of a writer,
// cleared by write-back or by flushing the writer. Macro: REGFILE_WB_BYPASS_EN.
module issue_scoreboard
  import issue_regfile_pkg::*;
#(
  parameter int NWORDS = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              kill_en_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              we_i,
  output logic              hazard_o
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [NWORDS-1:0] pending_q;
  logic [NWORDS-1:0] pending_d;
  logic              pend_s;
  logic              pend_t;

  // Clears first, set last, so a new writer wins over a same-cycle clear.
  always_comb begin
    pending_d = pending_q;
    if (kill_en_i)  pending_d[kill_addr_i] = 1'b0;
    if (wb_valid_i) pending_d[wb_addr_i]   = 1'b0;
    if (set_en_i)   pending_d[set_addr_i]  = 1'b1;
    pending_d[ZERO_A] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    pend_s = pending_q[rs_i];
    pend_t = pending_q[rt_i];
`ifdef REGFILE_WB_BYPASS_EN
    // A source being written back this cycle is forwarded, so it is not a hazard.
    if (wb_valid_i && (wb_addr_i == rs_i)) pend_s = 1'b0;
    if (wb_valid_i && (wb_addr_i == rt_i)) pend_t = 1'b0;
`endif
    hazard_o = pend_s | pend_t | (we_i & pending_q[rd_i]);
  end

endmodule

// File: rtl/issue_regfile.sv
// Register file with scoreboarded issue register (valid/ready toward execute).
// Macro: REGFILE_WB_BYPASS_EN enables same-cycle write-back forwarding to sources.
module issue_regfile
  import issue_regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 64,
  parameter int NBANK  = 2,
  parameter int ADDR_W = $clog2(NBANK * NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs,
  input  logic [ADDR_W-1:0] dec_rt,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_we,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [XLEN-1:0]   iss_s,
  output logic [XLEN-1:0]   iss_t,
  output logic [ADDR_W-1:0] iss_rd,
  output logic              iss_we,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush
);

  // Handshakes: dec side transfers when dec_valid & dec_ready; iss side transfers
  // when iss_valid & iss_ready. iss_* hold stable while iss_valid & !iss_ready.

  localparam int NWORDS = NBANK * NREG;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [XLEN-1:0]   mem_q [NWORDS];
  logic [XLEN-1:0]   op_s;
  logic [XLEN-1:0]   op_t;
  logic              hazard;
  logic              accept;

  logic              iss_valid_q, iss_valid_d;
  logic [XLEN-1:0]   iss_s_q, iss_s_d;
  logic [XLEN-1:0]   iss_t_q, iss_t_d;
  logic [ADDR_W-1:0] iss_rd_q, iss_rd_d;
  logic              iss_we_q, iss_we_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= '0;
    end else if (wb_valid && (wb_addr != ZERO_A)) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    op_s = mem_q[dec_rs];
    op_t = mem_q[dec_rt];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_valid && (wb_addr == dec_rs)) op_s = wb_data;
    if (wb_valid && (wb_addr == dec_rt)) op_t = wb_data;
`endif
    if (dec_rs == ZERO_A) op_s = '0;
    if (dec_rt == ZERO_A) op_t = '0;
  end

  issue_scoreboard #(
    .NWORDS (NWORDS),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .set_en_i    (accept & dec_we),
    .set_addr_i  (dec_rd),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .kill_en_i   (flush & iss_valid_q & iss_we_q),
    .kill_addr_i (iss_rd_q),
    .rs_i        (dec_rs),
    .rt_i        (dec_rt),
    .rd_i        (dec_rd),
    .we_i        (dec_we),
    .hazard_o    (hazard)
  );

  assign dec_ready = !flush && !hazard && (!iss_valid_q || iss_ready);
  assign accept    = dec_valid && dec_ready;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_s_d     = iss_s_q;
    iss_t_d     = iss_t_q;
    iss_rd_d    = iss_rd_q;
    iss_we_d    = iss_we_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d = 1'b1;
      iss_s_d     = op_s;
      iss_t_d     = op_t;
      iss_rd_d    = dec_rd;
      iss_we_d    = dec_we;
    end else if (iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      iss_valid_q <= 1'b0;
      iss_s_q     <= '0;
      iss_t_q     <= '0;
      iss_rd_q    <= '0;
      iss_we_q    <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_s_q     <= iss_s_d;
      iss_t_q     <= iss_t_d;
      iss_rd_q    <= iss_rd_d;
      iss_we_q    <= iss_we_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_s     = iss_s_q;
  assign iss_t     = iss_t_q;
  assign iss_rd    = iss_rd_q;
  assign iss_we    = iss_we_q;

endmodule

// File: tb/tb_issue_regfile.sv
// Directed bench for issue_regfile with a reference model checked every cycle.
module tb_issue_regfile;

  localparam int XLEN   = 32;
  localparam int NREG   = 64;
  localparam int NBANK  = 2;
  localparam int ADDR_W = 7;
  localparam int NW     = NBANK * NREG;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic              dec_valid, dec_ready, dec_we;
  logic [ADDR_W-1:0] dec_rs, dec_rt, dec_rd;
  logic              iss_valid, iss_ready, iss_we;
  logic [XLEN-1:0]   iss_s, iss_t;
  logic [ADDR_W-1:0] iss_rd;
  logic              wb_valid, flush;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  issue_regfile #(.XLEN(XLEN), .NREG(NREG), .NBANK(NBANK), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_we(dec_we),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_s(iss_s), .iss_t(iss_t), .iss_rd(iss_rd), .iss_we(iss_we),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0]   m_reg  [NW];
  bit                m_pend [NW];
  bit                m_iv, m_we;
  logic [XLEN-1:0]   m_s, m_t;
  logic [ADDR_W-1:0] m_rd;
  bit                m_init = 1'b0;

  function automatic bit src_busy(input logic [ADDR_W-1:0] a);
    if (BYPASS && wb_valid && wb_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = src_busy(dec_rs) || src_busy(dec_rt) || (dec_we && m_pend[dec_rd]);
    return !flush && !haz && (!m_iv || iss_ready);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && wb_valid && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NW; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
      m_iv = 0; m_we = 0; m_s = '0; m_t = '0; m_rd = '0;
      m_init = 1'b1;
    end else begin
      bit acc;
      logic [XLEN-1:0] s, t;
      acc = dec_valid && m_ready();
      s = m_read(dec_rs);
      t = m_read(dec_rt);
      if (flush && m_iv && m_we) m_pend[m_rd] = 1'b0;
      if (wb_valid) begin
        m_pend[wb_addr] = 1'b0;
        if (wb_addr != 0) m_reg[wb_addr] = wb_data;
      end
      if (acc && dec_we && dec_rd != 0) m_pend[dec_rd] = 1'b1;
      if (flush) m_iv = 0;
      else if (acc) begin m_iv = 1; m_s = s; m_t = t; m_rd = dec_rd; m_we = dec_we; end
      else if (iss_ready) m_iv = 0;
    end
  end

  // Compare process: mid-cycle, after inputs and DUT outputs have settled.
  always @(negedge clk) begin
    if (m_init && rstn) begin
      chk("dec_ready", 32'(dec_ready), 32'(m_ready()));
      chk("iss_valid", 32'(iss_valid), 32'(m_iv));
      if (m_iv) begin
        chk("iss_s",  iss_s, m_s);
        chk("iss_t",  iss_t, m_t);
        chk("iss_rd", 32'(iss_rd), 32'(m_rd));
        chk("iss_we", 32'(iss_we), 32'(m_we));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input bit v, input int rs, input int rt, input int rd, input bit we);
    dec_valid = v; dec_rs = ADDR_W'(rs); dec_rt = ADDR_W'(rt); dec_rd = ADDR_W'(rd); dec_we = we;
  endtask

  task automatic wb(input bit v, input int a, input logic [XLEN-1:0] d);
    wb_valid = v; wb_addr = ADDR_W'(a); wb_data = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rstn = 0; flush = 0; iss_ready = 1;
    dec(0, 0, 0, 0, 0);
    wb(0, 0, '0);
    cycle(); cycle();
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_s", iss_s, 0);
    chk("rst_iss_rd", 32'(iss_rd), 0);
    rstn = 1;
    #1 chk("rst_dec_ready", 32'(dec_ready), 1);

    // Preload and read two operands.
    wb(1, 3, 32'd7); cycle();
    wb(1, 5, 32'd9); cycle();
    wb(0, 0, '0);
    dec(1, 3, 5, 0, 0); cycle();
    dec(0, 0, 0, 0, 0);
    chk("rd_valid", 32'(iss_valid), 1);
    chk("rd_s", iss_s, 32'd7);
    chk("rd_t", iss_t, 32'd9);

    // RAW hazard on r4 released by write-back.
    dec(1, 0, 0, 4, 1); cycle();
    dec(1, 4, 0, 0, 0);
    #1 chk("raw_stall0", 32'(dec_ready), 0);
    cycle();
    chk("raw_stall1", 32'(dec_ready), 0);
    wb(1, 4, 32'h55);
    #1 chk("raw_wb_cycle", 32'(dec_ready), 32'(BYPASS));
    cycle();
    wb(0, 0, '0);
    if (!BYPASS) begin
      chk("raw_after_wb", 32'(dec_ready), 1);
      cycle();
    end
    dec(0, 0, 0, 0, 0);
    chk("raw_s", iss_s, 32'h55);
    chk("raw_valid", 32'(iss_valid), 1);

    // Zero register ignores writes and is never pending.
    wb(1, 0, 32'hFFFF); cycle();
    wb(0, 0, '0);
    dec(1, 0, 0, 0, 1);
    #1 chk("zero_nostall", 32'(dec_ready), 1);
    cycle();
    chk("zero_s", iss_s, 0);
    dec(1, 0, 0, 0, 0);
    #1 chk("zero_nopend", 32'(dec_ready), 1);
    cycle();

    // Back-pressure: hold for 3 cycles, then drain.
    dec(1, 3, 3, 0, 0); cycle();
    iss_ready = 0;
    dec(1, 5, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 32'(dec_ready), 0);
      chk("stall_s", iss_s, 32'd7);
      cycle();
    end
    iss_ready = 1;
    #1 chk("drain_ready", 32'(dec_ready), 1);
    cycle();
    dec(0, 0, 0, 0, 0);
    chk("drain_s", iss_s, 32'd9);
    cycle();
    chk("drain_empty", 32'(iss_valid), 0);

    // Flush a writer of r65; same-cycle write-back to r7 must land.
    iss_ready = 0;
    dec(1, 0, 0, 65, 1); cycle();
    dec(0, 0, 0, 0, 0);
    chk("fl_rd", 32'(iss_rd), 65);
    flush = 1;
    wb(1, 7, 32'h1234);
    #1 chk("fl_ready", 32'(dec_ready), 0);
    cycle();
    flush = 0; iss_ready = 1;
    wb(0, 0, '0);
    chk("fl_valid", 32'(iss_valid), 0);
    dec(1, 65, 7, 0, 0);
    #1 chk("fl_pend_clear", 32'(dec_ready), 1);
    cycle();
    dec(0, 0, 0, 0, 0);
    chk("fl_wb_kept", iss_t, 32'h1234);
    cycle();

    // Reset while r10 is pending and the issue register is stalled.
    dec(1, 0, 0, 10, 1); cycle();
    iss_ready = 0;
    dec(1, 10, 3, 0, 0);
    #1 chk("rs10_stall", 32'(dec_ready), 0);
    rstn = 0; cycle();
    rstn = 1; iss_ready = 1;
    #1 chk("rs10_ready", 32'(dec_ready), 1);
    cycle();
    dec(0, 0, 0, 0, 0);
    chk("rs10_s", iss_s, 0);
    chk("rs10_t_cleared", iss_t, 0);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
